score_display_ctrl: RTL and testbench

//   Pong scoreboard controller. Keeps both players' scores and detects the win.

---
 rtl/score_display_ctrl.sv | 75 +++++++
 tb/tb_score_display_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: Pong scoreboard with a shared 7-segment decoder
// time-multiplexed between both digits, plus winner blinking after game over.
module score_display_ctrl #(
  parameter int WIN_SCORE = 9,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       clear,
  output logic [3:0] dec_bcd,
  input  logic [6:0] dec_segments,
  output logic [6:0] seg_p1,
  output logic [6:0] seg_p2,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam int CW = $clog2(BLINK_DIV);
  typedef enum logic {PLAY, OVER} state_t;
  state_t          state_q;
  logic [3:0]      score1_q, score2_q, score1_d, score2_d;
  logic [1:0]      winner_q, win_d;
  logic            phase_q, blink_q;
  logic [CW-1:0]   blink_cnt_q;
  logic [6:0]      seg_p1_q, seg_p2_q;
  always_comb begin
    score1_d = score1_q + 4'(p1_point);
    score2_d = score2_q + 4'(p2_point);
    win_d    = {score2_d == 4'(WIN_SCORE), score1_d == 4'(WIN_SCORE)};
  end
  assign dec_bcd   = phase_q ? score2_q : score1_q;
  assign seg_p1    = seg_p1_q;
  assign seg_p2    = seg_p2_q;
  assign winner    = winner_q;
  assign game_over = state_q == OVER;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLAY;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= '0;
      phase_q     <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      seg_p1_q    <= '0;
      seg_p2_q    <= '0;
    end else begin
      phase_q <= ~phase_q;
      // The winner's digit is blanked at capture while blink is high
      if (!phase_q) seg_p1_q <= (winner_q[0] && blink_q) ? 7'h00 : dec_segments;
      else          seg_p2_q <= (winner_q[1] && blink_q) ? 7'h00 : dec_segments;
      if (clear) begin
        state_q     <= PLAY;
        score1_q    <= '0;
        score2_q    <= '0;
        winner_q    <= '0;
        blink_q     <= 1'b0;
        blink_cnt_q <= '0;
      end else if (state_q == PLAY) begin
        score1_q <= score1_d;
        score2_q <= score2_d;
        if (|win_d) begin
          state_q     <= OVER;
          winner_q    <= win_d;
          blink_q     <= 1'b0;
          blink_cnt_q <= '0;
        end
      end else begin
        blink_cnt_q <= (blink_cnt_q == CW'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + 1'b1;
        if (blink_cnt_q == CW'(BLINK_DIV - 1)) blink_q <= ~blink_q;
      end
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed vector table plus hand-written blink, clear
// and async-reset sequences for the Pong scoreboard controller.
module tb_score_display_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p1_point = 1'b0, p2_point = 1'b0, clear = 1'b0;
  logic [3:0] dec_bcd;
  logic [6:0] dec_segments, seg_p1, seg_p2;
  logic       game_over;
  logic [1:0] winner;
  int         n_pass = 0, n_total = 0;

  score_display_ctrl #(.WIN_SCORE(9), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .p1_point(p1_point), .p2_point(p2_point),
    .clear(clear), .dec_bcd(dec_bcd), .dec_segments(dec_segments),
    .seg_p1(seg_p1), .seg_p2(seg_p2), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h7E; 4'd1: seg7 = 7'h30; 4'd2: seg7 = 7'h6D; 4'd3: seg7 = 7'h79;
      4'd4: seg7 = 7'h33; 4'd5: seg7 = 7'h5B; 4'd6: seg7 = 7'h5F; 4'd7: seg7 = 7'h70;
      4'd8: seg7 = 7'h7F; 4'd9: seg7 = 7'h7B; default: seg7 = 7'h01;
    endcase
  endfunction
  assign dec_segments = seg7(dec_bcd);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step(input logic a, input logic b, input logic c);
    p1_point = a; p2_point = b; clear = c;
    @(posedge clk);
    #1;
    p1_point = 1'b0; p2_point = 1'b0; clear = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [6:0] s1, input logic [6:0] s2,
                         input logic go, input logic [1:0] w);
    chk({tag, " seg_p1"}, {1'b0, seg_p1}, {1'b0, s1});
    chk({tag, " seg_p2"}, {1'b0, seg_p2}, {1'b0, s2});
    chk({tag, " game_over"}, {7'b0, game_over}, {7'b0, go});
    chk({tag, " winner"}, {6'b0, winner}, {6'b0, w});
  endtask

  typedef struct packed {
    logic       p1, p2, clr;
    logic [6:0] s1, s2;
    logic       go;
    logic [1:0] w;
    logic [3:0] bcd;
  } vec_t;
  vec_t v[16];

  initial begin
    logic [3:0] b0, b1;
    // {p1, p2, clear, seg_p1, seg_p2, game_over, winner, dec_bcd} after each edge
    v[0]  = '{1'b0, 1'b0, 1'b0, 7'h7E, 7'h00, 1'b0, 2'b00, 4'd0};
    v[1]  = '{1'b0, 1'b0, 1'b0, 7'h7E, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[2]  = '{1'b1, 1'b0, 1'b0, 7'h7E, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[3]  = '{1'b1, 1'b0, 1'b0, 7'h7E, 7'h7E, 1'b0, 2'b00, 4'd2};
    v[4]  = '{1'b1, 1'b0, 1'b0, 7'h6D, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[5]  = '{1'b0, 1'b0, 1'b0, 7'h6D, 7'h7E, 1'b0, 2'b00, 4'd3};
    v[6]  = '{1'b0, 1'b0, 1'b0, 7'h79, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[7]  = '{1'b0, 1'b1, 1'b0, 7'h79, 7'h7E, 1'b0, 2'b00, 4'd3};
    v[8]  = '{1'b0, 1'b0, 1'b1, 7'h79, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[9]  = '{1'b0, 1'b0, 1'b0, 7'h79, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[10] = '{1'b0, 1'b0, 1'b0, 7'h7E, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[11] = '{1'b1, 1'b0, 1'b0, 7'h7E, 7'h7E, 1'b0, 2'b00, 4'd1};
    v[12] = '{1'b1, 1'b0, 1'b0, 7'h30, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[13] = '{1'b1, 1'b0, 1'b0, 7'h30, 7'h7E, 1'b0, 2'b00, 4'd3};
    v[14] = '{1'b0, 1'b0, 1'b0, 7'h79, 7'h7E, 1'b0, 2'b00, 4'd0};
    v[15] = '{1'b0, 1'b0, 1'b0, 7'h79, 7'h7E, 1'b0, 2'b00, 4'd3};

    #12;
    chk_all("reset", 7'h00, 7'h00, 1'b0, 2'b00);
    chk("reset dec_bcd", {4'b0, dec_bcd}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(v[i].p1, v[i].p2, v[i].clr);
      chk_all($sformatf("vec%0d", i), v[i].s1, v[i].s2, v[i].go, v[i].w);
      chk($sformatf("vec%0d dec_bcd", i), {4'b0, dec_bcd}, {4'b0, v[i].bcd});
    end

    // p2 reaches 9 while p1 holds 3
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 7) chk("p2 at 8 still playing", {7'b0, game_over}, 8'd0);
    end
    chk("p2 win game_over", {7'b0, game_over}, 8'd1);
    chk("p2 win winner", {6'b0, winner}, 8'd2);
    // pulses in OVER must be ignored; seg_p1 steady, seg_p2 blinks 4 on / 4 off
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (k % 2 == 0)
        chk_all($sformatf("p2 blink +%0d", k), 7'h79,
                (k == 6 || k == 8) ? 7'h00 : 7'h7B, 1'b1, 2'b10);
    end
    step(1'b0, 1'b0, 1'b0); b0 = dec_bcd;
    step(1'b0, 1'b0, 1'b0); b1 = dec_bcd;
    chk("scores held in OVER", {7'b0, (b0 == 4'd3 && b1 == 4'd9) || (b0 == 4'd9 && b1 == 4'd3)}, 8'd1);

    // clear with a simultaneous point drops the point
    step(1'b1, 1'b0, 1'b1);
    chk("clear game_over", {7'b0, game_over}, 8'd0);
    chk("clear winner", {6'b0, winner}, 8'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("clear dec_bcd a", {4'b0, dec_bcd}, 8'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("clear dec_bcd b", {4'b0, dec_bcd}, 8'd0);
    chk_all("after clear", 7'h7E, 7'h7E, 1'b0, 2'b00);

    // draw: 8/8 then simultaneous points
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 7) chk("8/8 still playing", {7'b0, game_over}, 8'd0);
    end
    chk("draw game_over", {7'b0, game_over}, 8'd1);
    chk("draw winner", {6'b0, winner}, 8'd3);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (k % 2 == 0)
        chk_all($sformatf("draw blink +%0d", k), (k == 6 || k == 8) ? 7'h00 : 7'h7B,
                (k == 6 || k == 8) ? 7'h00 : 7'h7B, 1'b1, 2'b11);
    end

    // async reset between edges during blink, with a point pending
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    p1_point = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk_all("async reset", 7'h00, 7'h00, 1'b0, 2'b00);
    chk("async reset dec_bcd", {4'b0, dec_bcd}, 8'd0);
    #2 rst_n = 1'b1;
    p1_point = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk_all("post reset 1", 7'h7E, 7'h00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    chk_all("post reset 2", 7'h7E, 7'h7E, 1'b0, 2'b00);
    chk("post reset dec_bcd", {4'b0, dec_bcd}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
